// File: rtl/dnn_result_unit.sv
// Result stage: captures engine class scores on a rising eng_done, runs a
// sequential argmax scan, and offers a registered indexed readback.
module dnn_result_unit #(
  parameter int DATA_WIDTH  = 13,
  parameter int NUM_CLASSES = 10,
  parameter int IDX_W       = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              eng_done,
  input  logic [NUM_CLASSES*DATA_WIDTH-1:0] scores_in,
  input  logic                              clear,
  input  logic [IDX_W-1:0]                  rd_idx,
  output logic signed [DATA_WIDTH-1:0]      rd_data,
  output logic                              rd_oor,
  output logic [IDX_W-1:0]                  pred_class,
  output logic signed [DATA_WIDTH-1:0]      pred_score,
  output logic                              pred_valid,
  output logic                              busy
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);
  localparam logic [IDX_W:0]   NUM_CLS  = (IDX_W + 1)'(NUM_CLASSES);

  state_t                              state, state_next;
  logic                                eng_done_d;
  logic                                cap;
  logic [NUM_CLASSES*DATA_WIDTH-1:0]   bank;
  logic [IDX_W-1:0]                    scan_idx;
  logic [IDX_W-1:0]                    best_idx;
  logic signed [DATA_WIDTH-1:0]        best_score;
  logic signed [DATA_WIDTH-1:0]        scan_elem;
  logic signed [DATA_WIDTH-1:0]        rd_elem;
  logic                                rd_hit;
  logic                                take;

  assign cap    = eng_done & ~eng_done_d;
  assign rd_hit = ({1'b0, rd_idx} < NUM_CLS);
  assign take   = (scan_elem > best_score);

  // Compare-based muxes keep index widths independent of NUM_CLASSES.
  always_comb begin
    scan_elem = '0;
    rd_elem   = '0;
    for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
      if (scan_idx == IDX_W'(k)) scan_elem = bank[k*DATA_WIDTH +: DATA_WIDTH];
      if (rd_idx == IDX_W'(k))   rd_elem   = bank[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (clear)                                     state_next = IDLE;
    else if (cap)                                  state_next = SCAN;
    else if (state == SCAN && scan_idx == LAST_IDX) state_next = DONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_done_d <= 1'b0;
      bank       <= '0;
      scan_idx   <= '0;
      best_idx   <= '0;
      best_score <= '0;
      pred_class <= '0;
      pred_score <= '0;
      pred_valid <= 1'b0;
      busy       <= 1'b0;
      rd_data    <= '0;
      rd_oor     <= 1'b0;
    end else begin
      eng_done_d <= eng_done;
      // Readback samples the bank as it was before this edge's capture/clear.
      rd_data    <= rd_hit ? rd_elem : '0;
      rd_oor     <= ~rd_hit;
      if (clear) begin
        bank       <= '0;
        pred_class <= '0;
        pred_score <= '0;
        pred_valid <= 1'b0;
        busy       <= 1'b0;
      end else if (cap) begin
        bank       <= scores_in;
        busy       <= 1'b1;
        pred_valid <= 1'b0;
        scan_idx   <= IDX_W'(1);
        best_idx   <= '0;
        best_score <= scores_in[DATA_WIDTH-1:0];
      end else if (state == SCAN) begin
        if (take) begin
          best_idx   <= scan_idx;
          best_score <= scan_elem;
        end
        if (scan_idx == LAST_IDX) begin
          pred_class <= take ? scan_idx : best_idx;
          pred_score <= take ? scan_elem : best_score;
          pred_valid <= 1'b1;
          busy       <= 1'b0;
        end else begin
          scan_idx <= scan_idx + 1'b1;
        end
      end
    end
  end

endmodule
